// File: rtl/conf_bus_pkg.sv
// Shared definitions for the SPI-to-config-bus bridge: command codes, frame length and FSM states.
package conf_bus_pkg;

    localparam logic CMD_WR      = 1'b1;
    localparam logic CMD_RD      = 1'b0;
    localparam int   RD_WAIT_CYC = 2;

    typedef enum logic [2:0] {
        WAIT_CSN_HI,
        IDLE,
        HDR,
        RD_WAIT,
        RDATA,
        WDATA,
        DONE
    } state_e;

    function automatic int flen(input int dw_ma, input int dw_md);
        return 1 + dw_ma + dw_md;
    endfunction

endpackage

// File: rtl/sync_edge.sv
// Multi-flop synchronizer for an asynchronous input, with single-clk rise/fall pulses.
module sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rstb,
    input  logic d_i,
    output logic lvl_o,
    output logic rise_o,
    output logic fall_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    // Reset to 0 so a frame already in flight at reset release produces no false csn edge.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign lvl_o  = sync_q[SYNC_STAGES-1];
    assign rise_o = sync_q[SYNC_STAGES-1] & ~prev_q;
    assign fall_o = ~sync_q[SYNC_STAGES-1] & prev_q;

endmodule

// File: rtl/spi_conf_bridge.sv
// SPI mode-0 slave that turns host frames (cmd, addr, data) into config-memory reads and writes.
module spi_conf_bridge
    import conf_bus_pkg::*;
#(
    parameter int DW_MA       = 8,
    parameter int DW_MD       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rstb,
    input  logic             spi_sck,
    input  logic             spi_csn,
    input  logic             spi_mosi,
    output logic             spi_miso,
    output logic [DW_MA-1:0] adr,
    output logic [DW_MD-1:0] wdt,
    output logic             val,
    input  logic [DW_MD-1:0] rdt,
    output logic             frame_err
);

    localparam int             FLEN      = flen(DW_MA, DW_MD);
    localparam int             CW        = $clog2(FLEN + 1);
    localparam logic [CW-1:0]  FLEN_C    = CW'(FLEN);
    localparam logic [CW-1:0]  LAST_BIT  = CW'(FLEN - 1);
    localparam logic [CW-1:0]  LAST_ADR  = CW'(DW_MA);
    localparam logic [1:0]     WAIT_LAST = 2'(RD_WAIT_CYC - 1);

    logic sck_rise, sck_fall, sck_lvl;
    logic csn_rise, csn_fall, csn_lvl;
    logic mosi;

    sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sck (
        .clk(clk), .rstb(rstb), .d_i(spi_sck),
        .lvl_o(sck_lvl), .rise_o(sck_rise), .fall_o(sck_fall)
    );
    sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_csn (
        .clk(clk), .rstb(rstb), .d_i(spi_csn),
        .lvl_o(csn_lvl), .rise_o(csn_rise), .fall_o(csn_fall)
    );
    sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_mosi (
        .clk(clk), .rstb(rstb), .d_i(spi_mosi),
        .lvl_o(mosi), .rise_o(), .fall_o()
    );

    state_e            state_q;
    logic [CW-1:0]     bitcnt_q, bitcnt_d;
    logic              cmd_q;
    logic [DW_MA-2:0]  rx_q;
    logic [DW_MD-1:0]  tx_q;
    logic [1:0]        wait_q;
    logic [DW_MA-1:0]  adr_q;
    logic [DW_MD-1:0]  wdt_q;
    logic              val_q, miso_q, ferr_q;

    assign bitcnt_d = (bitcnt_q == FLEN_C) ? bitcnt_q : bitcnt_q + 1'b1;

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q  <= WAIT_CSN_HI;
            bitcnt_q <= '0;
            cmd_q    <= CMD_RD;
            rx_q     <= '0;
            tx_q     <= '0;
            wait_q   <= '0;
            adr_q    <= '0;
            wdt_q    <= '0;
            val_q    <= 1'b0;
            miso_q   <= 1'b0;
            ferr_q   <= 1'b0;
        end else begin
            val_q  <= 1'b0;
            ferr_q <= 1'b0;
            if (csn_fall) bitcnt_q <= '0;
            case (state_q)
                WAIT_CSN_HI: if (csn_lvl) state_q <= IDLE;
                IDLE:        if (csn_fall) state_q <= HDR;
                HDR: begin
                    if (csn_rise) begin
                        ferr_q  <= 1'b1;
                        state_q <= IDLE;
                    end else if (sck_rise) begin
                        bitcnt_q <= bitcnt_d;
                        rx_q     <= {rx_q[DW_MA-3:0], mosi};
                        if (bitcnt_q == '0) cmd_q <= mosi;
                        if (bitcnt_q == LAST_ADR) begin
                            adr_q  <= {rx_q, mosi};
                            wait_q <= '0;
                            state_q <= (cmd_q == CMD_WR) ? WDATA : RD_WAIT;
                        end
                    end
                end
                RD_WAIT: begin
                    if (csn_rise) begin
                        ferr_q  <= 1'b1;
                        state_q <= IDLE;
                    end else begin
                        if (sck_rise) bitcnt_q <= bitcnt_d;
                        // rdt lags adr by one registered memory cycle.
                        if (wait_q == WAIT_LAST) begin
                            tx_q    <= rdt;
                            state_q <= RDATA;
                        end else begin
                            wait_q <= wait_q + 1'b1;
                        end
                    end
                end
                RDATA: begin
                    if (csn_rise) begin
                        ferr_q  <= 1'b1;
                        miso_q  <= 1'b0;
                        state_q <= IDLE;
                    end else if (sck_fall) begin
                        miso_q <= tx_q[DW_MD-1];
                        tx_q   <= {tx_q[DW_MD-2:0], 1'b0};
                    end else if (sck_rise) begin
                        bitcnt_q <= bitcnt_d;
                        if (bitcnt_q == LAST_BIT) begin
                            miso_q  <= 1'b0;
                            state_q <= DONE;
                        end
                    end
                end
                WDATA: begin
                    // A final rise coinciding with csn rise still commits the write.
                    if (sck_rise) begin
                        bitcnt_q <= bitcnt_d;
                        wdt_q    <= {wdt_q[DW_MD-2:0], mosi};
                        if (bitcnt_q == LAST_BIT) begin
                            val_q   <= 1'b1;
                            state_q <= csn_rise ? IDLE : DONE;
                        end else if (csn_rise) begin
                            ferr_q  <= 1'b1;
                            state_q <= IDLE;
                        end
                    end else if (csn_rise) begin
                        ferr_q  <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                DONE:    if (csn_rise) state_q <= IDLE;
                default: state_q <= WAIT_CSN_HI;
            endcase
        end
    end

    assign adr       = adr_q;
    assign wdt       = wdt_q;
    assign val       = val_q;
    assign spi_miso  = miso_q;
    assign frame_err = ferr_q;

endmodule

// File: tb/tb_spi_conf_bridge.sv
// Directed bench for spi_conf_bridge with a registered-read config memory model; f_sck = f_clk/8.
module tb_spi_conf_bridge;

    logic        clk = 1'b0;
    logic        rstb = 1'b0;
    logic        spi_sck = 1'b0;
    logic        spi_csn = 1'b1;
    logic        spi_mosi = 1'b0;
    logic        spi_miso;
    logic [7:0]  adr;
    logic [15:0] wdt;
    logic        val;
    logic [15:0] rdt = '0;
    logic        frame_err;

    logic [15:0] mem [256];
    logic        pre_we = 1'b0;
    logic [7:0]  pre_adr = '0;
    logic [15:0] pre_dat = '0;

    int n_vec = 0;
    int n_mis = 0;
    int val_cnt = 0;
    int ferr_cnt = 0;
    logic [7:0]  cap_adr = '0;
    logic [15:0] cap_wdt = '0;
    logic [15:0] host_rx = '0;

    always #5 clk = ~clk;

    spi_conf_bridge dut (
        .clk(clk), .rstb(rstb),
        .spi_sck(spi_sck), .spi_csn(spi_csn), .spi_mosi(spi_mosi), .spi_miso(spi_miso),
        .adr(adr), .wdt(wdt), .val(val), .rdt(rdt), .frame_err(frame_err)
    );

    always @(posedge clk) begin
        if (pre_we) mem[pre_adr] <= pre_dat;
        else if (val) mem[adr] <= wdt;
        rdt <= mem[adr];
    end

    always @(negedge clk) begin
        if (val) begin
            val_cnt = val_cnt + 1;
            cap_adr = adr;
            cap_wdt = wdt;
        end
        if (frame_err) ferr_cnt = ferr_cnt + 1;
    end

    task automatic chk_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic hp();
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic csn_low();
        spi_csn = 1'b0;
        hp();
    endtask

    task automatic csn_high();
        hp();
        spi_csn = 1'b1;
        repeat (4) hp();
    endtask

    task automatic send_bits(input logic [31:0] vec, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            spi_mosi = vec[i];
            hp();
            host_rx = {host_rx[14:0], spi_miso};
            spi_sck = 1'b1;
            hp();
            spi_sck = 1'b0;
        end
        spi_mosi = 1'b0;
    endtask

    task automatic frame(input logic [31:0] vec, input int n);
        csn_low();
        send_bits(vec, n);
        csn_high();
    endtask

    int v0, f0;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = '0;
        repeat (3) @(posedge clk);
        #1;
        chk_vec("rst_adr", {24'h0, adr}, 32'h0);
        chk_vec("rst_wdt", {16'h0, wdt}, 32'h0);
        chk_vec("rst_val", {31'h0, val}, 32'h0);
        chk_vec("rst_miso", {31'h0, spi_miso}, 32'h0);
        chk_vec("rst_ferr", {31'h0, frame_err}, 32'h0);
        rstb = 1'b1;
        repeat (4) hp();

        // 1: plain write
        v0 = val_cnt; f0 = ferr_cnt;
        frame({7'h0, 1'b1, 8'h02, 16'hBEEF}, 25);
        chk_vec("t1_val_cnt", val_cnt - v0, 1);
        chk_vec("t1_adr", {24'h0, cap_adr}, 32'h02);
        chk_vec("t1_wdt", {16'h0, cap_wdt}, 32'hBEEF);
        chk_vec("t1_ferr", ferr_cnt - f0, 0);

        // 2: read of a preloaded location
        @(posedge clk); #1;
        pre_adr = 8'h01; pre_dat = 16'h1234; pre_we = 1'b1;
        @(posedge clk); #1;
        pre_we = 1'b0;
        v0 = val_cnt; f0 = ferr_cnt;
        frame({7'h0, 1'b0, 8'h01, 16'h0000}, 25);
        chk_vec("t2_rdata", {16'h0, host_rx}, 32'h1234);
        chk_vec("t2_val_cnt", val_cnt - v0, 0);
        chk_vec("t2_ferr", ferr_cnt - f0, 0);
        chk_vec("t2_adr", {24'h0, adr}, 32'h01);
        chk_vec("t2_miso_idle", {31'h0, spi_miso}, 32'h0);

        // 3: aborted write, then full write
        v0 = val_cnt; f0 = ferr_cnt;
        frame({12'h0, 1'b1, 8'h03, 11'h555}, 20);
        chk_vec("t3_abort_val", val_cnt - v0, 0);
        chk_vec("t3_abort_ferr", ferr_cnt - f0, 1);
        v0 = val_cnt; f0 = ferr_cnt;
        frame({7'h0, 1'b1, 8'h03, 16'h5A5A}, 25);
        chk_vec("t3_val_cnt", val_cnt - v0, 1);
        chk_vec("t3_adr", {24'h0, cap_adr}, 32'h03);
        chk_vec("t3_wdt", {16'h0, cap_wdt}, 32'h5A5A);
        chk_vec("t3_ferr", ferr_cnt - f0, 0);

        // 4: reset in the middle of a write
        v0 = val_cnt; f0 = ferr_cnt;
        csn_low();
        send_bits({20'h0, 1'b1, 8'h07, 3'b101}, 12);
        rstb = 1'b0;
        @(posedge clk); #1;
        chk_vec("t4_rst_adr", {24'h0, adr}, 32'h0);
        chk_vec("t4_rst_wdt", {16'h0, wdt}, 32'h0);
        chk_vec("t4_rst_val", {31'h0, val}, 32'h0);
        repeat (2) @(posedge clk); #1;
        rstb = 1'b1;
        send_bits({19'h0, 13'h1ACE}, 13);
        csn_high();
        chk_vec("t4_val_cnt", val_cnt - v0, 0);
        chk_vec("t4_ferr", ferr_cnt - f0, 0);
        chk_vec("t4_adr_hold", {24'h0, adr}, 32'h0);
        chk_vec("t4_wdt_hold", {16'h0, wdt}, 32'h0);
        v0 = val_cnt;
        frame({7'h0, 1'b1, 8'h00, 16'h0055}, 25);
        chk_vec("t4_new_val_cnt", val_cnt - v0, 1);
        chk_vec("t4_new_adr", {24'h0, cap_adr}, 32'h00);
        chk_vec("t4_new_wdt", {16'h0, cap_wdt}, 32'h0055);

        // 5: write with five extra bits
        v0 = val_cnt; f0 = ferr_cnt;
        frame({2'b0, 1'b1, 8'h04, 16'hCAFE, 5'b10101}, 30);
        chk_vec("t5_val_cnt", val_cnt - v0, 1);
        chk_vec("t5_adr", {24'h0, cap_adr}, 32'h04);
        chk_vec("t5_wdt", {16'h0, cap_wdt}, 32'hCAFE);
        chk_vec("t5_ferr", ferr_cnt - f0, 0);

        // 6: back-to-back write then read of the same address
        v0 = val_cnt; f0 = ferr_cnt;
        frame({7'h0, 1'b1, 8'h05, 16'h0F0F}, 25);
        frame({7'h0, 1'b0, 8'h05, 16'h0000}, 25);
        chk_vec("t6_rdata", {16'h0, host_rx}, 32'h0F0F);
        chk_vec("t6_val_cnt", val_cnt - v0, 1);
        chk_vec("t6_ferr", ferr_cnt - f0, 0);
        repeat (3) hp();
        chk_vec("t6_adr_hold", {24'h0, adr}, 32'h05);

        // 7: read aborted in its data phase
        v0 = val_cnt; f0 = ferr_cnt;
        frame({17'h0, 1'b0, 8'h02, 6'h00}, 15);
        chk_vec("t7_val_cnt", val_cnt - v0, 0);
        chk_vec("t7_ferr", ferr_cnt - f0, 1);
        chk_vec("t7_miso", {31'h0, spi_miso}, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
